// File: rtl/pushpop_sequencer.sv
// Multi-cycle Thumb PUSH/POP register-list sequencer: walks the latched register list,
// issuing one memory beat per cycle, then writes back SP (and PC for POP {..., pc}).
module pushpop_sequencer #(
  parameter int unsigned NUM_LO_REGS = 8,
  parameter int unsigned WORD_WIDTH  = 32,
  parameter int unsigned MEM_WIDTH   = 16,
  parameter int unsigned ADDR_WIDTH  = 12
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   is_pop,
  input  logic [NUM_LO_REGS-1:0] reg_list,
  input  logic                   extra_reg,
  input  logic [WORD_WIDTH-1:0]  sp_in,
  output logic [3:0]             rf_rd_addr,
  input  logic [WORD_WIDTH-1:0]  rf_rd_data,
  output logic                   rf_wr_en,
  output logic [3:0]             rf_wr_addr,
  output logic [WORD_WIDTH-1:0]  rf_wr_data,
  output logic                   sp_wr_en,
  output logic [WORD_WIDTH-1:0]  sp_wr_data,
  output logic                   pc_update,
  output logic [WORD_WIDTH-1:0]  pc_wr_data,
  output logic                   stall_to_instructionfetch,
  output logic                   done,
  output logic                   mem_enable,
  output logic                   mem_read_enable,
  output logic                   mem_write_enable,
  output logic [ADDR_WIDTH-1:0]  mem_address,
  output logic [MEM_WIDTH-1:0]   mem_wdata,
  input  logic [MEM_WIDTH-1:0]   mem_rdata
);

  localparam int unsigned Beats     = WORD_WIDTH / MEM_WIDTH;
  localparam int unsigned BeatW     = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned MaskW     = NUM_LO_REGS + 1;
  localparam int unsigned IdxW      = $clog2(MaskW);
  localparam int unsigned CntW      = $clog2(MaskW + 1);
  localparam int unsigned BeatBytes = MEM_WIDTH / 8;
  localparam int unsigned ByteShift = $clog2(BeatBytes);

  typedef enum logic [1:0] {StIdle, StCalc, StXfer, StDone} state_e;

  state_e                state_q, state_d;
  logic                  is_pop_q, is_pop_d;
  logic [MaskW-1:0]      mask_q, mask_d;
  logic [WORD_WIDTH-1:0] sp_q, sp_d;
  logic [WORD_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] new_sp_q, new_sp_d;
  logic [BeatW-1:0]      beat_q, beat_d;
  // POP return pipeline: describes the beat whose data is on mem_rdata this cycle
  logic                  rd_valid_q, rd_valid_d;
  logic                  rd_last_q, rd_last_d;
  logic [3:0]            rd_reg_q, rd_reg_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;

  logic [CntW-1:0]       cnt;
  logic [WORD_WIDTH-1:0] four_n;
  logic [IdxW-1:0]       cur_idx;
  logic [3:0]            cur_reg;
  logic [MaskW-1:0]      mask_next;
  logic                  beat_last;
  logic [WORD_WIDTH-1:0] assembled;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < int'(MaskW); i++) begin
      cnt = cnt + CntW'(mask_q[i]);
    end
    four_n = WORD_WIDTH'(cnt) << 2;
  end

  // Lowest set bit of the remaining list is the register currently in flight.
  always_comb begin
    cur_idx = '0;
    for (int i = int'(MaskW) - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        cur_idx = IdxW'(i);
      end
    end
  end

  assign cur_reg   = (cur_idx == IdxW'(NUM_LO_REGS)) ? (is_pop_q ? 4'd15 : 4'd14) : 4'(cur_idx);
  assign mask_next = mask_q & ~(MaskW'(1) << cur_idx);
  assign beat_last = (beat_q == BeatW'(Beats - 1));

  // Beats arrive LSB first; shifting each new beat in from the top leaves the word aligned
  // once the last beat lands.
  assign assembled = (shift_q >> MEM_WIDTH)
                   | (WORD_WIDTH'(mem_rdata) << (WORD_WIDTH - MEM_WIDTH));

  always_comb begin
    state_d    = state_q;
    is_pop_d   = is_pop_q;
    mask_d     = mask_q;
    sp_d       = sp_q;
    addr_d     = addr_q;
    new_sp_d   = new_sp_q;
    beat_d     = beat_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    rd_reg_d   = rd_reg_q;
    shift_d    = shift_q;

    if (rd_valid_q) begin
      shift_d = assembled;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          is_pop_d = is_pop;
          mask_d   = {extra_reg, reg_list};
          sp_d     = sp_in;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        if (is_pop_q) begin
          addr_d   = sp_q;
          new_sp_d = sp_q + four_n;
        end else begin
          addr_d   = sp_q - four_n;
          new_sp_d = sp_q - four_n;
        end
        beat_d  = '0;
        state_d = (cnt == '0) ? StDone : StXfer;
      end
      StXfer: begin
        addr_d     = addr_q + WORD_WIDTH'(BeatBytes);
        rd_valid_d = is_pop_q;
        rd_last_d  = beat_last;
        rd_reg_d   = cur_reg;
        if (beat_last) begin
          beat_d = '0;
          mask_d = mask_next;
          if (mask_next == '0) begin
            state_d = StDone;
          end
        end else begin
          beat_d = beat_q + BeatW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= StIdle;
      is_pop_q   <= 1'b0;
      mask_q     <= '0;
      sp_q       <= '0;
      addr_q     <= '0;
      new_sp_q   <= '0;
      beat_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_reg_q   <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      is_pop_q   <= is_pop_d;
      mask_q     <= mask_d;
      sp_q       <= sp_d;
      addr_q     <= addr_d;
      new_sp_q   <= new_sp_d;
      beat_q     <= beat_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_reg_q   <= rd_reg_d;
      shift_q    <= shift_d;
    end
  end

  always_comb begin
    rf_rd_addr                = '0;
    rf_wr_en                  = 1'b0;
    rf_wr_addr                = '0;
    rf_wr_data                = '0;
    sp_wr_en                  = 1'b0;
    sp_wr_data                = '0;
    pc_update                 = 1'b0;
    pc_wr_data                = '0;
    stall_to_instructionfetch = (state_q != StIdle);
    done                      = 1'b0;
    mem_enable                = 1'b0;
    mem_read_enable           = 1'b0;
    mem_write_enable          = 1'b0;
    mem_address               = '0;
    mem_wdata                 = '0;

    if (state_q == StXfer) begin
      mem_enable  = 1'b1;
      mem_address = ADDR_WIDTH'(addr_q >> ByteShift);
      if (is_pop_q) begin
        mem_read_enable = 1'b1;
      end else begin
        mem_write_enable = 1'b1;
        rf_rd_addr       = cur_reg;
        mem_wdata        = MEM_WIDTH'(rf_rd_data >> (int'(beat_q) * int'(MEM_WIDTH)));
      end
    end

    if (state_q == StDone) begin
      sp_wr_en   = 1'b1;
      sp_wr_data = new_sp_q;
      done       = 1'b1;
    end

    if (rd_valid_q && rd_last_q) begin
      if (rd_reg_q == 4'd15) begin
        pc_update  = 1'b1;
        pc_wr_data = assembled & ~WORD_WIDTH'(1);
      end else begin
        rf_wr_en   = 1'b1;
        rf_wr_addr = rd_reg_q;
        rf_wr_data = assembled;
      end
    end
  end

endmodule

// File: doc/pushpop_sequencer.md
Name: pushpop_sequencer

Overview:
- Multi-cycle sequencer that executes Thumb PUSH/POP register-list instructions as a series of memory beats. It is the parametrised successor to the fixed PUSH {r7,lr} / POP {r7,pc} path.
- Generalised in register-list width and memory port width. A 32-bit register takes WORD_WIDTH/MEM_WIDTH beats.
- Sits between the decoder and the memory controller.
- Stalls instruction fetch while active, and writes back SP, the listed registers and, for POP with PC, the program counter.

Parameters:
- NUM_LO_REGS, 8, number of low registers addressable by reg_list (r0..rNUM_LO_REGS-1).
- WORD_WIDTH, 32, register width in bits.
- MEM_WIDTH, 16, memory data port width. Legal values are 16 or 32; WORD_WIDTH/MEM_WIDTH gives B = beats per register.
- ADDR_WIDTH, 12, memory word-address width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- start  in  1  one-cycle request from decoder; sampled only in IDLE.
- is_pop  in  1  1 = POP, 0 = PUSH; sampled with start.
- reg_list  in  NUM_LO_REGS  register list bitmap; sampled with start.
- extra_reg  in  1  PUSH: include LR (r14); POP: include PC (r15).
- sp_in  in  WORD_WIDTH  current SP byte address; sampled with start.
- rf_rd_addr  out  4  register-file read index; the RF responds combinationally.
- rf_rd_data  in  WORD_WIDTH  register-file read data, same cycle as rf_rd_addr.
- rf_wr_en  out  1  register write strobe.
- rf_wr_addr  out  4  register write index (0..14).
- rf_wr_data  out  WORD_WIDTH  register write data.
- sp_wr_en  out  1  SP write strobe.
- sp_wr_data  out  WORD_WIDTH  new SP value.
- pc_update  out  1  PC write strobe; POP with PC only.
- pc_wr_data  out  WORD_WIDTH  popped PC value with bit0 cleared.
- stall_to_instructionfetch  out  1  high while the sequencer is busy.
- done  out  1  one-cycle completion pulse.
- mem_enable, mem_read_enable, mem_write_enable  out  1 each  memory controls.
- mem_address  out  ADDR_WIDTH  memory word address = byte_addr >> log2(MEM_WIDTH/8), truncated.
- mem_wdata  out  MEM_WIDTH  write data.
- mem_rdata  in  MEM_WIDTH  read data, valid the cycle after mem_read_enable.

Behaviour:
- Reset (reset=0 at a clock edge):
  - FSM goes to IDLE.
  - All outputs are 0, including all strobes, stall, done and mem_address.
  - Reset mid-operation aborts immediately: no further memory accesses, no SP/RF/PC write, and registers already written by a POP stay written.
- Register count and addressing:
  - N = popcount(reg_list) + extra_reg.
  - PUSH: base = sp_in - 4N, new SP = base.
  - POP: base = sp_in, new SP = sp_in + 4N.
  - Registers transfer in ascending index order (low regs, then LR/PC) to ascending addresses starting at base.
  - Each register occupies 4 bytes, little-endian; the lowest memory word holds the least significant bits.
- States:
  - IDLE: start=1 latches the inputs and goes to CALC. start=0 stays in IDLE.
  - CALC (1 cycle): stall=1; computes N and base; selects the first register.
    - N=0 goes straight to DONE with SP unchanged and no memory access.
  - XFER (N*B cycles): one beat per cycle.
    - PUSH: drives mem_enable=mem_write_enable=1; rf_rd_addr is the current register; mem_wdata is beat k of rf_rd_data (k=0 is the LSB part).
    - POP: drives mem_enable=mem_read_enable=1. Each returned beat is captured the next cycle. rf_wr_en (or pc_update for r15) pulses in the cycle the register's last beat is returned, with data = {last beat, captured lower beats}.
  - DONE (1 cycle): sp_wr_en=1 with the new SP; done=1; stall=1; mem enables 0.
    - POP: the last register's write coincides with DONE.
    - Next state is IDLE.
- Latency: PUSH and POP with N>0 both take N*B+2 cycles from the first stall cycle to done inclusive. N=0 takes 2 cycles.
- stall_to_instructionfetch is 1 from the cycle after start is accepted through DONE inclusive; it drops in the cycle after done.
- start while not in IDLE is ignored.
- Address arithmetic:
  - SP arithmetic is modulo 2^WORD_WIDTH.
  - mem_address wraps modulo 2^ADDR_WIDTH; no fault is generated.
- rf_wr_addr is never 13 (SP) or 15. PC goes only through pc_update.
- POP of PC: pc_wr_data = data & ~1.

Test Plan:
- PUSH {r7,lr}, MEM_WIDTH=16, sp_in=0x100, r7=0x12345678, lr=0xCAFEBABE:
  - Writes 0x7C←0x5678, 0x7D←0x1234, 0x7E←0xBABE, 0x7F←0xCAFE.
  - sp_wr_data=0xF8; stall 6 cycles; done in cycle 6.
- POP {r7,pc} from sp_in=0xF8 on the memory image above:
  - r7←0x12345678; pc_update with pc_wr_data=0xCAFEBABE.
  - SP←0x100; no rf write to 15.
- PUSH with reg_list=0, extra_reg=0:
  - No mem_enable; sp_wr_data=sp_in; done in cycle 2.
- PUSH {r0,r2,r5,lr}, MEM_WIDTH=32, sp_in=0x200:
  - 4 single-beat writes at word addresses 0x7C..0x7F in order r0, r2, r5, lr.
  - SP=0x1F0; total 6 cycles.
- reset=0 during the third XFER cycle of a POP:
  - All outputs are 0 next cycle; no SP write.
  - A later start runs normally.
- start pulsed again mid-PUSH:
  - Ignored; exactly one done pulse and one SP update.
